// File: rtl/dso_pkg.sv
// Shared types for the DSO wave read side: FSM state encoding, sample width
// and small sample compare helpers.
package dso_pkg;

  localparam int DSO_SAMPLE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_READ,
    ST_DRAIN,
    ST_RELEASE,
    ST_HOLD
  } rd_state_e;

  function automatic logic [DSO_SAMPLE_W-1:0] sample_max(
    input logic [DSO_SAMPLE_W-1:0] a, input logic [DSO_SAMPLE_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DSO_SAMPLE_W-1:0] sample_min(
    input logic [DSO_SAMPLE_W-1:0] a, input logic [DSO_SAMPLE_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/dso_rd_skid.sv
// Two-entry skid buffer holding {data, index, last} between the RAM return
// stage and the valid/ready output. Entry 0 is always the head, so the output
// stays stable while stalled. Flush empties it without touching contents.
module dso_rd_skid
  import dso_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic [DSO_SAMPLE_W-1:0] push_data,
  input  logic [AW-1:0]           push_index,
  input  logic                    push_last,
  output logic                    pop_valid,
  input  logic                    pop_ready,
  output logic [DSO_SAMPLE_W-1:0] pop_data,
  output logic [AW-1:0]           pop_index,
  output logic                    pop_last,
  output logic [1:0]              level
);

  logic [1:0][DSO_SAMPLE_W-1:0] ent_data;
  logic [1:0][AW-1:0]           ent_idx;
  logic [1:0]                   ent_last;
  logic                         pop;

  assign pop_valid = (level != 2'd0);
  assign pop       = pop_valid && pop_ready;
  assign pop_data  = ent_data[0];
  assign pop_index = ent_idx[0];
  assign pop_last  = ent_last[0];

  // Occupancy and entry shuffle; push never hits a full buffer (credit upstream)
  always_ff @(posedge clk) begin
    if (rst) begin
      level    <= 2'd0;
      ent_data <= '0;
      ent_idx  <= '0;
      ent_last <= '0;
    end else if (flush) begin
      level <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (level == 2'd0) begin
            ent_data[0] <= push_data;
            ent_idx[0]  <= push_index;
            ent_last[0] <= push_last;
          end else begin
            ent_data[1] <= push_data;
            ent_idx[1]  <= push_index;
            ent_last[1] <= push_last;
          end
          level <= level + 2'd1;
        end
        2'b01: begin
          ent_data[0] <= ent_data[1];
          ent_idx[0]  <= ent_idx[1];
          ent_last[0] <= ent_last[1];
          level       <= level - 2'd1;
        end
        2'b11: begin
          if (level == 2'd1) begin
            ent_data[0] <= push_data;
            ent_idx[0]  <= push_index;
            ent_last[0] <= push_last;
          end else begin
            ent_data[0] <= ent_data[1];
            ent_idx[0]  <= ent_idx[1];
            ent_last[0] <= ent_last[1];
            ent_data[1] <= push_data;
            ent_idx[1]  <= push_index;
            ent_last[1] <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dso_wave_reader.sv
// DSO sample buffer read side. Waits for a captured frame plus a request,
// reads HORIZONTAL samples starting PRE_TRIG before the trigger address,
// streams them over valid/ready and pulses ram_refresh to release the half.
// Optional feature macro: DSO_WAVE_PEAK_EN (per-frame min/max outputs).
module dso_wave_reader
  import dso_pkg::*;
#(
  parameter int HORIZONTAL = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int PRE_TRIG   = 512,
  parameter int HOLD_CYC   = 4
) (
  input  logic                    ram_rd_clk,
  input  logic                    rd_rst,
  input  logic                    wave_run,
  input  logic                    frame_req,
  input  logic                    wave_ready,
  input  logic [ADDR_WIDTH-1:0]   wave_trig_addr,
  output logic [ADDR_WIDTH-1:0]   wave_rd_addr,
  input  logic [DSO_SAMPLE_W-1:0] wave_rd_data,
  output logic                    ram_refresh,
  output logic [DSO_SAMPLE_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [ADDR_WIDTH-1:0]   out_index,
  output logic                    busy
`ifdef DSO_WAVE_PEAK_EN
  ,
  output logic [DSO_SAMPLE_W-1:0] peak_max,
  output logic [DSO_SAMPLE_W-1:0] peak_min,
  output logic                    peak_valid
`endif
);

  localparam int             AW       = ADDR_WIDTH;
  localparam int             HCW      = $clog2(HOLD_CYC + 1);
  localparam logic [AW:0]    H_EXT    = (AW+1)'(HORIZONTAL);
  localparam logic [AW:0]    BACK     = (AW+1)'(HORIZONTAL - PRE_TRIG);
  localparam logic [AW-1:0]  LAST_IDX = AW'(HORIZONTAL - 1);
  localparam logic [HCW-1:0] HOLD_END = HCW'(HOLD_CYC - 1);

  rd_state_e      state, state_n;
  logic           req_latched, req_hit, go;
  logic [AW-1:0]  issue_idx;
  logic           ret_vld, ret_last;
  logic [AW-1:0]  ret_idx;
  logic [HCW-1:0] hold_cnt;
  logic [1:0]     skid_level;
  logic [2:0]     occ;
  logic           accept, issue;
  logic [AW:0]    trig_ext, trig_mod, start_sum;
  logic [AW-1:0]  start_addr;

  assign accept      = out_valid && out_ready;
  assign go          = (state == ST_IDLE) && req_latched && wave_ready && wave_run;
  assign ram_refresh = (state == ST_RELEASE);
  assign busy        = (state != ST_IDLE);

  // Frame start = trigger folded into range, stepped back PRE_TRIG with wrap
  assign trig_ext   = {1'b0, wave_trig_addr};
  assign trig_mod   = (trig_ext >= H_EXT) ? trig_ext - H_EXT : trig_ext;
  assign start_sum  = trig_mod + BACK;
  assign start_addr = AW'((start_sum >= H_EXT) ? start_sum - H_EXT : start_sum);

  // Credit: after this edge at most one word may sit in flight + skid, so the
  // word issued now always finds a free skid slot when it returns.
  always_comb begin
    occ   = {1'b0, skid_level} + {2'b0, ret_vld};
    issue = (state == ST_READ) && (occ <= (3'd1 + {2'b0, accept}));
  end

  // Next-state decode; run low aborts from any state
  always_comb begin
    state_n = state;
    if (!wave_run) begin
      state_n = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:    if (go) state_n = ST_LOAD;
        ST_LOAD:    state_n = ST_READ;
        ST_READ:    if (issue && (issue_idx == LAST_IDX)) state_n = ST_DRAIN;
        ST_DRAIN:   if (accept && out_last) state_n = ST_RELEASE;
        ST_RELEASE: state_n = ST_HOLD;
        ST_HOLD:    if (hold_cnt == HOLD_END) state_n = ST_IDLE;
        default:    state_n = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge ram_rd_clk) begin
    if (rd_rst) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Request latch; a request arriving on the IDLE exit cycle survives LOAD
  always_ff @(posedge ram_rd_clk) begin
    if (rd_rst) begin
      req_latched <= 1'b0;
      req_hit     <= 1'b0;
    end else begin
      req_hit <= go && frame_req;
      if (frame_req)
        req_latched <= 1'b1;
      else if ((state == ST_LOAD) && wave_run && !req_hit)
        req_latched <= 1'b0;
    end
  end

  // Address issue, return tag stage and HOLD counter
  always_ff @(posedge ram_rd_clk) begin
    if (rd_rst) begin
      wave_rd_addr <= '0;
      issue_idx    <= '0;
      ret_vld      <= 1'b0;
      ret_idx      <= '0;
      ret_last     <= 1'b0;
      hold_cnt     <= '0;
    end else begin
      ret_vld  <= issue && wave_run;
      ret_idx  <= issue_idx;
      ret_last <= (issue_idx == LAST_IDX);
      if (state == ST_LOAD) begin
        wave_rd_addr <= start_addr;
        issue_idx    <= '0;
      end else if (issue) begin
        wave_rd_addr <= (wave_rd_addr == LAST_IDX) ? '0 : wave_rd_addr + 1'b1;
        issue_idx    <= issue_idx + 1'b1;
      end
      hold_cnt <= (state == ST_HOLD) ? hold_cnt + 1'b1 : '0;
    end
  end

  dso_rd_skid #(.AW(AW)) u_skid (
    .clk        (ram_rd_clk),
    .rst        (rd_rst),
    .flush      (!wave_run),
    .push       (ret_vld),
    .push_data  (wave_rd_data),
    .push_index (ret_idx),
    .push_last  (ret_last),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (out_data),
    .pop_index  (out_index),
    .pop_last   (out_last),
    .level      (skid_level)
  );

`ifdef DSO_WAVE_PEAK_EN
  logic [DSO_SAMPLE_W-1:0] run_max, run_min;

  // Running min/max over accepted samples, published as the frame completes
  always_ff @(posedge ram_rd_clk) begin
    if (rd_rst) begin
      run_max    <= '0;
      run_min    <= '1;
      peak_max   <= '0;
      peak_min   <= '1;
      peak_valid <= 1'b0;
    end else begin
      peak_valid <= 1'b0;
      if (!wave_run || (state == ST_LOAD)) begin
        run_max <= '0;
        run_min <= '1;
      end else if (accept) begin
        run_max <= sample_max(run_max, out_data);
        run_min <= sample_min(run_min, out_data);
        if ((state == ST_DRAIN) && out_last) begin
          peak_max   <= sample_max(run_max, out_data);
          peak_min   <= sample_min(run_min, out_data);
          peak_valid <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_dso_wave_reader.sv
// Directed bench for dso_wave_reader: frame ordering, wrap, stalls, abort,
// back-to-back requests and mid-frame reset against a small RAM model.
module tb_dso_wave_reader;

  logic       ram_rd_clk = 1'b0;
  logic       rd_rst, wave_run, frame_req, wave_ready, out_ready;
  logic [9:0] wave_trig_addr, wave_rd_addr, out_index;
  logic [7:0] wave_rd_data, out_data;
  logic       ram_refresh, out_valid, out_last, busy;
`ifdef DSO_WAVE_PEAK_EN
  logic [7:0] peak_max, peak_min;
  logic       peak_valid;
`endif

  logic [7:0] mem [1024];
  int checks   = 0;
  int failures = 0;
  int nacc, nref, gap, tl, cnt;

  dso_wave_reader #(
    .HORIZONTAL(1024), .ADDR_WIDTH(10), .PRE_TRIG(512), .HOLD_CYC(4)
  ) dut (
    .ram_rd_clk     (ram_rd_clk),
    .rd_rst         (rd_rst),
    .wave_run       (wave_run),
    .frame_req      (frame_req),
    .wave_ready     (wave_ready),
    .wave_trig_addr (wave_trig_addr),
    .wave_rd_addr   (wave_rd_addr),
    .wave_rd_data   (wave_rd_data),
    .ram_refresh    (ram_refresh),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .out_index      (out_index),
    .busy           (busy)
`ifdef DSO_WAVE_PEAK_EN
    ,
    .peak_max       (peak_max),
    .peak_min       (peak_min),
    .peak_valid     (peak_valid)
`endif
  );

  always #5 ram_rd_clk = ~ram_rd_clk;

  // Synchronous-read RAM: data for the address seen at an edge appears after it
  always @(posedge ram_rd_clk) wave_rd_data <= mem[wave_rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one frame from the current negedge; returns sample count, refresh
  // count, cycles from refresh to IDLE, and the cycle busy first went high.
  task automatic run_frame(input bit do_req, input bit rnd, input int abort_idx,
                           input int req_idx, input logic [9:0] trig, input int exp_start,
                           output int n_acc, output int n_ref, output int n_gap,
                           output int t_load);
    int t_first, t_last, t_ref, cyc;
    bit prev_stall, aborted, done;
    logic [7:0] pd, mx, mn;
    logic [9:0] pi;
    logic pl;
    n_acc = 0; n_ref = 0; n_gap = -1; t_load = -1;
    t_first = -1; t_last = -1; t_ref = -1;
    prev_stall = 0; aborted = 0; done = 0;
    mx = 8'h00; mn = 8'hFF; pd = '0; pi = '0; pl = 1'b0;
    wave_trig_addr = trig;
    for (cyc = 1; cyc <= 6000 && !done; cyc++) begin
      @(negedge ram_rd_clk);
      frame_req = do_req && (cyc == 1);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (busy && t_load < 0) t_load = cyc;
      if (t_load >= 0 && cyc == t_load + 1) chk("start_addr", wave_rd_addr, exp_start);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, pd);
        chk("stall_index", out_index, pi);
        chk("stall_last", out_last, pl);
      end
      if (out_valid && t_first < 0) begin
        t_first = cyc;
        chk("first_valid_latency", t_first - t_load, 3);
      end
      if (ram_refresh) begin
        n_ref++;
        t_ref = cyc;
        chk("refresh_after_last", t_ref, t_last + 1);
`ifdef DSO_WAVE_PEAK_EN
        chk("peak_valid", peak_valid, 1);
        chk("peak_max", peak_max, mx);
        chk("peak_min", peak_min, mn);
`endif
      end
      if (aborted) begin
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        done = 1;
      end else if (out_valid && out_ready) begin
        chk("index", out_index, n_acc);
        chk("data", out_data, mem[(exp_start + n_acc) % 1024]);
        chk("last", out_last, n_acc == 1023);
        if (out_data > mx) mx = out_data;
        if (out_data < mn) mn = out_data;
        if (n_acc == abort_idx) begin wave_run = 1'b0; aborted = 1; end
        if (n_acc == req_idx) frame_req = 1'b1;
        n_acc++;
        t_last = cyc;
      end
      prev_stall = out_valid && !out_ready;
      pd = out_data; pi = out_index; pl = out_last;
      if (!done && t_ref >= 0 && !busy) begin
        n_gap = cyc - t_ref;
        done = 1;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $error("FAIL frame_timeout observed=%0d expected=%0d", n_acc, 1024);
    end
    if (!rnd && abort_idx < 0 && t_first >= 0 && t_last >= 0)
      chk("throughput", t_last - t_first, 1023);
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 8'((a * 37 + (a >> 4) * 11 + 5) & 255);
    rd_rst = 1'b1; wave_run = 1'b1; frame_req = 1'b0; wave_ready = 1'b1;
    out_ready = 1'b1; wave_trig_addr = '0;

    // Reset values
    repeat (3) @(negedge ram_rd_clk);
    chk("rst_rd_addr", wave_rd_addr, 0);
    chk("rst_refresh", ram_refresh, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_index", out_index, 0);
    chk("rst_busy", busy, 0);
    rd_rst = 1'b0;

    // No request: stays idle even with a frame available
    repeat (5) @(negedge ram_rd_clk);
    chk("idle_no_req", busy, 0);

    // Request latched while no frame is ready, served once wave_ready rises
    wave_ready = 1'b0;
    @(negedge ram_rd_clk); frame_req = 1'b1;
    @(negedge ram_rd_clk); frame_req = 1'b0;
    repeat (4) @(negedge ram_rd_clk);
    chk("ready_gate", busy, 0);
    wave_ready = 1'b1;

    // Frame A: trigger 600 -> start 88, full-rate output
    run_frame(0, 0, -1, -1, 10'd600, 88, nacc, nref, gap, tl);
    chk("a_count", nacc, 1024);
    chk("a_refresh", nref, 1);
    chk("a_hold_gap", gap, 5);

    // Frame B: trigger 100 -> start 612, index 512 reads address 100
    run_frame(1, 0, -1, -1, 10'd100, 612, nacc, nref, gap, tl);
    chk("b_count", nacc, 1024);
    chk("b_refresh", nref, 1);
    chk("b_hold_gap", gap, 5);

    // Frame C: random back-pressure
    run_frame(1, 1, -1, -1, 10'd600, 88, nacc, nref, gap, tl);
    chk("c_count", nacc, 1024);
    chk("c_refresh", nref, 1);

    // Abort at index 300, then a fresh full frame
    run_frame(1, 0, 300, -1, 10'd600, 88, nacc, nref, gap, tl);
    chk("abort_count", nacc, 301);
    chk("abort_refresh", nref, 0);
    cnt = 0;
    repeat (6) begin @(negedge ram_rd_clk); if (ram_refresh) cnt++; end
    chk("abort_no_refresh_after", cnt, 0);
    wave_run = 1'b1;
    run_frame(1, 0, -1, -1, 10'd600, 88, nacc, nref, gap, tl);
    chk("rerun_count", nacc, 1024);
    chk("rerun_refresh", nref, 1);

    // Request during READ: next frame leaves IDLE right after HOLD
    run_frame(1, 0, -1, 500, 10'd100, 612, nacc, nref, gap, tl);
    chk("b2b_first_gap", gap, 5);
    run_frame(0, 0, -1, -1, 10'd100, 612, nacc, nref, gap, tl);
    chk("b2b_second_load", tl, 1);
    chk("b2b_second_count", nacc, 1024);

    // Reset mid-frame: everything back to idle, no release pulse
    @(negedge ram_rd_clk); frame_req = 1'b1;
    @(negedge ram_rd_clk); frame_req = 1'b0;
    repeat (20) @(negedge ram_rd_clk);
    chk("pre_rst_busy", busy, 1);
    rd_rst = 1'b1;
    @(negedge ram_rd_clk);
    rd_rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_addr", wave_rd_addr, 0);
    chk("midrst_index", out_index, 0);
    cnt = 0;
    repeat (8) begin @(negedge ram_rd_clk); if (ram_refresh) cnt++; end
    chk("midrst_no_refresh", cnt, 0);
    chk("midrst_req_cleared", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
